// File: rtl/matrix_cps_pkg.sv
// Shared types and sizing for the matrix dispatch stage: FU and datatype encodings, FSM states
// and the issue-register payload.
package matrix_cps_pkg;

  localparam int unsigned N_REGS                = 8;
  localparam int unsigned MAX_NUM_READ_OPERANDS = 3;
  localparam int unsigned N_FU                  = 3;
  localparam int unsigned RD_CNT_W              = 2;

  localparam int unsigned REG_W   = $clog2(N_REGS);
  localparam int unsigned NREAD_W = $clog2(MAX_NUM_READ_OPERANDS);
  localparam int unsigned FU_W    = $clog2(N_FU);

  typedef enum logic [1:0] {
    FuSystolic = 2'd0,
    FuLsu      = 2'd1,
    FuRfZero   = 2'd2
  } execution_units_t;

  typedef enum logic [1:0] {
    DtInt8  = 2'd0,
    DtInt16 = 2'd1,
    DtInt32 = 2'd2,
    DtFp32  = 2'd3
  } datatype_t;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } dispatch_state_t;

  typedef struct packed {
    logic [MAX_NUM_READ_OPERANDS-1:0][REG_W-1:0] read_regs;
    logic [NREAD_W-1:0]                          n_read;
    logic [REG_W-1:0]                            wb_reg;
    logic                                        wb;
    datatype_t                                   datatype;
    logic                                        is_store;
    logic                                        is_float;
  } issue_payload_t;

  // Unencoded values fall back to the systolic array so the index never leaves [0, N_FU).
  function automatic logic [FU_W-1:0] fu_idx(input execution_units_t eu);
    return (eu == FuRfZero) ? FU_W'(2) : (eu == FuLsu) ? FU_W'(1) : FU_W'(0);
  endfunction

endpackage

// File: rtl/matrix_cps_scoreboard.sv
// Per-register hazard tracking: pending-write bits, outstanding-reader counters, hazard
// detection for the held instruction and a sticky protocol error flag.
module matrix_cps_scoreboard
  import matrix_cps_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [MAX_NUM_READ_OPERANDS-1:0][REG_W-1:0] read_regs_i,
  input  logic [NREAD_W-1:0]                          n_read_i,
  input  logic                                        wb_i,
  input  logic [REG_W-1:0]                            wb_reg_i,
  input  logic                                        fire_i,
  input  logic [N_REGS-1:0]                           rd_release_i,
  input  logic [N_REGS-1:0]                           wb_done_i,
  output logic                                        hazard_o,
  output logic [N_REGS-1:0]                           busy_o,
  output logic                                        clear_o,
  output logic                                        protocol_err_o
);

  localparam logic [RD_CNT_W-1:0] CntMax = '1;

  logic [N_REGS-1:0]               busy_q, busy_d;
  logic [N_REGS-1:0][RD_CNT_W-1:0] cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic [N_REGS-1:0]               read_set, cnt_nz, cnt_sat, inc, dec, wb_set;

  // Duplicated operand indices collapse into one bit of the read set.
  always_comb begin
    read_set = '0;
    for (int i = 0; i < MAX_NUM_READ_OPERANDS; i++) begin
      if (i < int'(n_read_i)) read_set[read_regs_i[i]] = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
      cnt_nz[r]  = |cnt_q[r];
      cnt_sat[r] = (cnt_q[r] == CntMax);
    end
  end

  // The issuing instruction's own reads are not yet counted, so WAR sees only other readers.
  assign hazard_o = (|(read_set & busy_q))
                  | (wb_i & busy_q[wb_reg_i])
                  | (wb_i & cnt_nz[wb_reg_i])
                  | (|(read_set & cnt_sat));

  assign inc = {N_REGS{fire_i}} & read_set;
  assign dec = rd_release_i & cnt_nz;

  always_comb begin
    wb_set = '0;
    if (fire_i && wb_i) wb_set[wb_reg_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < N_REGS; r++) begin
      case ({inc[r], dec[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + RD_CNT_W'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - RD_CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    busy_d = (busy_q & ~wb_done_i) | wb_set;
    err_d  = err_q | (|(rd_release_i & ~cnt_nz)) | (|(wb_done_i & ~busy_q));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_o         = busy_q;
  assign clear_o        = ~(|busy_q) & ~(|cnt_nz);
  assign protocol_err_o = err_q;

endmodule

// File: rtl/matrix_cps_dispatcher.sv
// In-order single-issue dispatch stage: one-entry issue register, FU handshake and flush,
// with register hazards resolved by the scoreboard.
module matrix_cps_dispatcher
  import matrix_cps_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        instr_valid_i,
  output logic                                        instr_ready_o,
  input  logic [NREAD_W-1:0]                          n_read_i,
  input  logic [MAX_NUM_READ_OPERANDS-1:0][REG_W-1:0] read_regs_i,
  input  logic                                        wb_i,
  input  logic [REG_W-1:0]                            wb_reg_i,
  input  execution_units_t                            exec_unit_i,
  input  logic                                        is_store_i,
  input  logic                                        is_float_i,
  input  datatype_t                                   datatype_i,
  input  logic                                        flush_i,
  output logic [N_FU-1:0]                             issue_valid_o,
  input  logic [N_FU-1:0]                             issue_ready_i,
  output logic [MAX_NUM_READ_OPERANDS-1:0][REG_W-1:0] issue_read_regs_o,
  output logic [NREAD_W-1:0]                          issue_n_read_o,
  output logic [REG_W-1:0]                            issue_wb_reg_o,
  output logic                                        issue_wb_o,
  output datatype_t                                   issue_datatype_o,
  output logic                                        issue_is_store_o,
  output logic                                        issue_is_float_o,
  input  logic [N_REGS-1:0]                           rd_release_i,
  input  logic [N_REGS-1:0]                           wb_done_i,
  output logic [N_REGS-1:0]                           busy_o,
  output logic                                        idle_o,
  output logic                                        protocol_err_o
);

  dispatch_state_t  state_q, state_d;
  issue_payload_t   pl_q, pl_d;
  execution_units_t eu_q, eu_d;
  logic             hazard, fire, load, sb_clear, holding;
  logic [FU_W-1:0]  fu;

  assign holding       = (state_q == S_HOLD);
  assign fu            = fu_idx(eu_q);
  assign fire          = holding & ~hazard & issue_ready_i[fu] & ~flush_i;
  assign instr_ready_o = ~flush_i & (~holding | fire);
  assign load          = instr_valid_i & instr_ready_o;

  always_comb begin
    issue_valid_o = '0;
    if (holding && !hazard) issue_valid_o[fu] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    eu_d    = eu_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else if (load) begin
      state_d          = S_HOLD;
      eu_d             = exec_unit_i;
      pl_d.read_regs   = read_regs_i;
      pl_d.n_read      = n_read_i;
      pl_d.wb_reg      = wb_reg_i;
      pl_d.wb          = wb_i;
      pl_d.datatype    = datatype_i;
      pl_d.is_store    = is_store_i;
      pl_d.is_float    = is_float_i;
    end else if (fire) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      pl_q    <= '0;
      eu_q    <= FuSystolic;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      eu_q    <= eu_d;
    end
  end

  matrix_cps_scoreboard u_scoreboard (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .read_regs_i    (pl_q.read_regs),
    .n_read_i       (pl_q.n_read),
    .wb_i           (pl_q.wb),
    .wb_reg_i       (pl_q.wb_reg),
    .fire_i         (fire),
    .rd_release_i   (rd_release_i),
    .wb_done_i      (wb_done_i),
    .hazard_o       (hazard),
    .busy_o         (busy_o),
    .clear_o        (sb_clear),
    .protocol_err_o (protocol_err_o)
  );

  assign idle_o            = ~holding & sb_clear;
  assign issue_read_regs_o = pl_q.read_regs;
  assign issue_n_read_o    = pl_q.n_read;
  assign issue_wb_reg_o    = pl_q.wb_reg;
  assign issue_wb_o        = pl_q.wb;
  assign issue_datatype_o  = pl_q.datatype;
  assign issue_is_store_o  = pl_q.is_store;
  assign issue_is_float_o  = pl_q.is_float;

endmodule

// File: tb/tb_matrix_cps_dispatcher.sv
// Bench for matrix_cps_dispatcher: directed scenarios plus randomized traffic, all checked
// every cycle against a set-and-counter model of the dispatch rules.
module tb_matrix_cps_dispatcher;
  import matrix_cps_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [1:0]       n_read = '0;
  logic [2:0][2:0]  read_regs = '0;
  logic             wb = 1'b0;
  logic [2:0]       wb_reg = '0;
  execution_units_t exec_unit = FuSystolic;
  logic             is_store = 1'b0;
  logic             is_float = 1'b0;
  datatype_t        datatype = DtInt8;
  logic             flush = 1'b0;
  logic [2:0]       issue_valid;
  logic [2:0]       issue_ready = '1;
  logic [2:0][2:0]  issue_read_regs;
  logic [1:0]       issue_n_read;
  logic [2:0]       issue_wb_reg;
  logic             issue_wb;
  datatype_t        issue_datatype;
  logic             issue_is_store;
  logic             issue_is_float;
  logic [7:0]       rd_release = '0;
  logic [7:0]       wb_done = '0;
  logic [7:0]       busy;
  logic             idle;
  logic             protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_cps_dispatcher dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .instr_valid_i     (instr_valid),
    .instr_ready_o     (instr_ready),
    .n_read_i          (n_read),
    .read_regs_i       (read_regs),
    .wb_i              (wb),
    .wb_reg_i          (wb_reg),
    .exec_unit_i       (exec_unit),
    .is_store_i        (is_store),
    .is_float_i        (is_float),
    .datatype_i        (datatype),
    .flush_i           (flush),
    .issue_valid_o     (issue_valid),
    .issue_ready_i     (issue_ready),
    .issue_read_regs_o (issue_read_regs),
    .issue_n_read_o    (issue_n_read),
    .issue_wb_reg_o    (issue_wb_reg),
    .issue_wb_o        (issue_wb),
    .issue_datatype_o  (issue_datatype),
    .issue_is_store_o  (issue_is_store),
    .issue_is_float_o  (issue_is_float),
    .rd_release_i      (rd_release),
    .wb_done_i         (wb_done),
    .busy_o            (busy),
    .idle_o            (idle),
    .protocol_err_o    (protocol_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the held instruction, busy flags and reader counts.
  localparam int CntMax = (1 << RD_CNT_W) - 1;
  bit       h_valid = 0;
  int       h_eu = 0, h_nread = 0, h_wbreg = 0, h_dt = 0;
  int       h_regs[3] = '{0, 0, 0};
  bit       h_wb = 0, h_st = 0, h_fl = 0;
  bit       m_busy[8];
  int       m_cnt[8];
  bit       m_err = 0;
  bit [7:0] m_rset;
  bit       m_hz, m_fire, m_rdy, m_clean;
  logic [2:0] m_iv;
  logic [7:0] m_busyv;
  logic [2:0][2:0] m_rr;

  always @(negedge clk) begin
    m_rset = '0;
    for (int i = 0; i < 3; i++) if (i < h_nread) m_rset[h_regs[i]] = 1'b1;
    m_hz = 0;
    for (int r = 0; r < 8; r++) if (m_rset[r] && (m_busy[r] || m_cnt[r] == CntMax)) m_hz = 1;
    if (h_wb && (m_busy[h_wbreg] || m_cnt[h_wbreg] != 0)) m_hz = 1;
    m_iv = '0;
    if (h_valid && !m_hz) m_iv[h_eu] = 1'b1;
    m_fire  = h_valid && !m_hz && issue_ready[h_eu] && !flush;
    m_rdy   = !flush && (!h_valid || m_fire);
    m_clean = 1;
    for (int r = 0; r < 8; r++) begin
      m_busyv[r] = m_busy[r];
      if (m_busy[r] || m_cnt[r] != 0) m_clean = 0;
    end
    check("issue_valid", 32'(issue_valid), 32'(m_iv));
    check("instr_ready", 32'(instr_ready), 32'(m_rdy));
    check("busy", 32'(busy), 32'(m_busyv));
    check("idle", 32'(idle), 32'(!h_valid && m_clean));
    check("protocol_err", 32'(protocol_err), 32'(m_err));
    if (h_valid) begin
      for (int i = 0; i < 3; i++) m_rr[i] = 3'(h_regs[i]);
      check("payload_regs", 32'(issue_read_regs), 32'(m_rr));
      check("payload_fields",
            32'({issue_n_read, issue_wb, issue_wb_reg, issue_datatype, issue_is_store,
                 issue_is_float}),
            32'({2'(h_nread), h_wb, 3'(h_wbreg), 2'(h_dt), h_st, h_fl}));
    end
    if (!rst_n) begin
      h_valid = 0; h_eu = 0; h_nread = 0; h_wbreg = 0; h_dt = 0; h_wb = 0; h_st = 0; h_fl = 0;
      for (int r = 0; r < 8; r++) begin m_busy[r] = 0; m_cnt[r] = 0; end
      m_err = 0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (rd_release[r] && m_cnt[r] == 0) m_err = 1;
        if (wb_done[r] && !m_busy[r]) m_err = 1;
        m_cnt[r] = m_cnt[r] + ((m_fire && m_rset[r]) ? 1 : 0)
                   - ((rd_release[r] && m_cnt[r] > 0) ? 1 : 0);
        m_busy[r] = (m_busy[r] && !wb_done[r]) || (m_fire && h_wb && h_wbreg == r);
      end
      if (flush) h_valid = 0;
      else if (instr_valid && m_rdy) begin
        h_valid = 1; h_eu = int'(exec_unit); h_nread = int'(n_read);
        for (int i = 0; i < 3; i++) h_regs[i] = int'(read_regs[i]);
        h_wb = wb; h_wbreg = int'(wb_reg); h_dt = int'(datatype); h_st = is_store; h_fl = is_float;
      end else if (m_fire) h_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    instr_valid = 0; flush = 0; rd_release = '0; wb_done = '0; issue_ready = '1;
  endtask

  task automatic put(input execution_units_t eu, input int nr, input int a, input int b,
                     input int c, input bit w, input int wr);
    instr_valid = 1; exec_unit = eu; n_read = 2'(nr);
    read_regs[0] = 3'(a); read_regs[1] = 3'(b); read_regs[2] = 3'(c);
    wb = w; wb_reg = 3'(wr);
    datatype = datatype_t'(2'($urandom_range(0, 3)));
    is_store = 1'($urandom_range(0, 1)); is_float = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 0; quiet(); step(); step(); rst_n = 1;
  endtask

  task automatic check_reset_values(input string tag);
    #1;
    check({tag, "_iv"}, 32'(issue_valid), 32'(0));
    check({tag, "_rdy"}, 32'(instr_ready), 32'(1));
    check({tag, "_idle"}, 32'(idle), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_err"}, 32'(protocol_err), 32'(0));
    check({tag, "_payload"}, 32'({issue_read_regs, issue_n_read, issue_wb_reg, issue_wb}),
          32'(0));
  endtask

  // Retires every outstanding reader and pending write known to the model.
  task automatic drain();
    int k = 0;
    bit dirty = 1;
    quiet();
    while (k < 20 && dirty) begin
      dirty = 0;
      for (int r = 0; r < 8; r++) begin
        rd_release[r] = (m_cnt[r] > 0);
        wb_done[r]    = m_busy[r];
        if (m_cnt[r] > 0 || m_busy[r]) dirty = 1;
      end
      step();
      k++;
    end
    quiet();
    #1;
    check("drain_idle", 32'(idle), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset_values("reset");

    // Independent back-to-back: MLD_W r1 then MST_W from r2.
    put(FuLsu, 0, 0, 0, 0, 1, 1); #1;
    check("t1_accept", 32'(instr_ready), 32'(1));
    step();
    put(FuLsu, 1, 2, 0, 0, 0, 0); #1;
    check("t1_mld_issue", 32'(issue_valid), 32'(3'b010));
    check("t1_no_stall", 32'(instr_ready), 32'(1));
    step();
    quiet(); #1;
    check("t1_busy", 32'(busy), 32'(8'h02));
    check("t1_mst_issue", 32'(issue_valid), 32'(3'b010));
    step();
    drain();

    // RAW: MMASA_W reads r1 while MLD_W to r1 is outstanding.
    put(FuLsu, 0, 0, 0, 0, 1, 1); step();
    put(FuSystolic, 2, 1, 2, 0, 1, 0); step();
    quiet(); #1;
    check("t2_raw_hold", 32'(issue_valid), 32'(0));
    step(); step(); step();
    wb_done = 8'h02; #1;
    check("t2_raw_hold_c5", 32'(issue_valid), 32'(0));
    step();
    wb_done = '0; #1;
    check("t2_raw_release", 32'(issue_valid), 32'(3'b001));
    step();
    drain();

    // Saturation on r3 after three readers, then WAR for a load to r3.
    repeat (4) begin put(FuLsu, 1, 3, 0, 0, 0, 0); step(); end
    quiet(); #1;
    check("t3_sat_stall", 32'(issue_valid), 32'(0));
    check("t3_sat_not_ready", 32'(instr_ready), 32'(0));
    flush = 1; #1;
    check("t3_flush_not_ready", 32'(instr_ready), 32'(0));
    step();
    quiet(); put(FuLsu, 0, 0, 0, 0, 1, 3); #1;
    check("t3_empty_ready", 32'(instr_ready), 32'(1));
    step();
    quiet(); rd_release = 8'h08; #1;
    check("t3_war_stall", 32'(issue_valid), 32'(0));
    step(); step(); #1;
    check("t3_war_stall_last", 32'(issue_valid), 32'(0));
    step();
    rd_release = '0; #1;
    check("t3_war_release", 32'(issue_valid), 32'(3'b010));
    step();
    drain();

    // Fire of an r4 reader coinciding with a release of r4.
    put(FuLsu, 1, 4, 0, 0, 0, 0); step();
    put(FuLsu, 1, 4, 4, 0, 0, 0); step();
    quiet(); rd_release = 8'h10; #1;
    check("t4_fire", 32'(issue_valid), 32'(3'b010));
    step();
    rd_release = 8'h10; step();
    quiet(); #1;
    check("t4_cnt_kept", 32'(idle), 32'(1));
    check("t4_no_err", 32'(protocol_err), 32'(0));

    // Protocol errors.
    wb_done = 8'h40; step();
    quiet(); #1;
    check("t5_done_err", 32'(protocol_err), 32'(1));
    do_reset();
    check_reset_values("t5_reset");
    rd_release = 8'h20; step();
    quiet(); #1;
    check("t5_rel_err", 32'(protocol_err), 32'(1));
    step(); step(); step(); #1;
    check("t5_sticky", 32'(protocol_err), 32'(1));
    do_reset();

    // Flush a held instruction, then reset in the middle of a hold.
    put(FuLsu, 0, 0, 0, 0, 1, 7); step();
    put(FuRfZero, 0, 0, 0, 0, 1, 0); issue_ready = 3'b011; step();
    quiet(); issue_ready = 3'b011; #1;
    check("t6_hold_valid", 32'(issue_valid), 32'(3'b100));
    check("t6_hold_not_ready", 32'(instr_ready), 32'(0));
    flush = 1; step();
    flush = 0; #1;
    check("t6_flushed", 32'(issue_valid), 32'(0));
    check("t6_busy_kept", 32'(busy), 32'(8'h80));
    check("t6_not_idle", 32'(idle), 32'(0));
    put(FuRfZero, 1, 2, 0, 0, 1, 5); issue_ready = 3'b011; step();
    quiet(); issue_ready = 3'b011; rst_n = 0; step();
    rst_n = 1; quiet();
    check_reset_values("t6_reset");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      exec_unit = execution_units_t'(2'($urandom_range(0, 2)));
      n_read = 2'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) read_regs[i] = 3'($urandom_range(0, 7));
      wb = 1'($urandom_range(0, 1));
      wb_reg = 3'($urandom_range(0, 7));
      datatype = datatype_t'(2'($urandom_range(0, 3)));
      is_store = 1'($urandom_range(0, 1));
      is_float = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      issue_ready = 3'($urandom_range(0, 7));
      for (int r = 0; r < 8; r++) begin
        rd_release[r] = (m_cnt[r] > 0 && $urandom_range(0, 2) == 0) ||
                        ($urandom_range(0, 255) == 0);
        wb_done[r] = (m_busy[r] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 255) == 0);
      end
      step();
    end
    rst_n = 1;
    quiet();
    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
